// File: rtl/poly_inverse_search.sv
// Purpose : finds the smallest x in 0..2^XW-1 with c0+c1*x+c2*x^2+c3*x^3 == target (mod 2^YW).
// Latency : 4 cycles per candidate (3 Horner steps + 1 compare); done pulses one cycle after the decision.
// Backpr. : start is only sampled in IDLE; start while busy or done is ignored.
// Option  : define POLY_INV_COUNT_EN to scan the full range and report the number of solutions on count.
module poly_inverse_search #(
    parameter int XW = 2,
    parameter int YW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [YW-1:0] c0,
    input  logic [YW-1:0] c1,
    input  logic [YW-1:0] c2,
    input  logic [YW-1:0] c3,
    input  logic [YW-1:0] target,
    output logic          busy,
    output logic          done,
    output logic          found,
`ifdef POLY_INV_COUNT_EN
    output logic [XW:0]   count,
`endif
    output logic [XW-1:0] x_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] acc_q, acc_d;
    logic [1:0]    step_q, step_d;
    logic [YW-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [YW-1:0] tgt_q, tgt_d;
    logic          found_q, found_d;
    logic [XW-1:0] x_out_q, x_out_d;
`ifdef POLY_INV_COUNT_EN
    logic [XW:0]   count_q, count_d;
`endif

    // Shared multiplier and Horner coefficient select; product truncated before the add.
    logic [YW-1:0]   x_ext;
    logic [2*YW-1:0] prod_full;
    logic [YW-1:0]   coef_sel;
    logic            match;
    logic            x_last;

    always_comb begin
        x_ext     = YW'(x_q);
        prod_full = acc_q * x_ext;
        case (step_q)
            2'd0:    coef_sel = c2_q;
            2'd1:    coef_sel = c1_q;
            default: coef_sel = c0_q;
        endcase
        match  = (acc_q == tgt_q);
        x_last = (x_q == {XW{1'b1}});
    end

    // Next-state logic: load on start, iterate Horner steps, decide at compare.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        step_d  = step_q;
        c0_d    = c0_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        tgt_d   = tgt_q;
        found_d = found_q;
        x_out_d = x_out_q;
`ifdef POLY_INV_COUNT_EN
        count_d = count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    c0_d    = c0;
                    c1_d    = c1;
                    c2_d    = c2;
                    c3_d    = c3;
                    tgt_d   = target;
                    x_d     = '0;
                    acc_d   = c3;
                    step_d  = 2'd0;
`ifdef POLY_INV_COUNT_EN
                    count_d = '0;
`endif
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                acc_d = prod_full[YW-1:0] + coef_sel;
                if (step_q == 2'd2) begin
                    state_d = S_CMP;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            S_CMP: begin
`ifdef POLY_INV_COUNT_EN
                // Full scan: the first match of the run (count still zero) owns x_out.
                if (match) begin
                    count_d = count_q + (XW+1)'(1);
                    if (count_q == '0) begin
                        found_d = 1'b1;
                        x_out_d = x_q;
                    end
                end
                if (x_last) begin
                    if (!match && count_q == '0) begin
                        found_d = 1'b0;
                        x_out_d = '0;
                    end
                    state_d = S_DONE;
                end else begin
                    x_d     = x_q + XW'(1);
                    acc_d   = c3_q;
                    step_d  = 2'd0;
                    state_d = S_EVAL;
                end
`else
                // Early exit on the first match; x stops at its maximum, never wraps.
                if (match) begin
                    found_d = 1'b1;
                    x_out_d = x_q;
                    state_d = S_DONE;
                end else if (x_last) begin
                    found_d = 1'b0;
                    x_out_d = '0;
                    state_d = S_DONE;
                end else begin
                    x_d     = x_q + XW'(1);
                    acc_d   = c3_q;
                    step_d  = 2'd0;
                    state_d = S_EVAL;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any search in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            c0_q    <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            c3_q    <= '0;
            tgt_q   <= '0;
            found_q <= 1'b0;
            x_out_q <= '0;
`ifdef POLY_INV_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            c3_q    <= c3_d;
            tgt_q   <= tgt_d;
            found_q <= found_d;
            x_out_q <= x_out_d;
`ifdef POLY_INV_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy  = (state_q == S_EVAL) || (state_q == S_CMP);
        done  = (state_q == S_DONE);
        found = found_q;
        x_out = x_out_q;
`ifdef POLY_INV_COUNT_EN
        count = count_q;
`endif
    end

endmodule

// File: tb/tb_poly_inverse_search.sv
// Purpose : directed checks of poly_inverse_search (XW=2, YW=5) against hand-computed results.
// Latency : counts edges from the accepting edge E0 to the first cycle with done high.
// Backpr. : exercises start while busy, start during done, and async reset mid-search.
module tb_poly_inverse_search;

    localparam int XW = 2;
    localparam int YW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [YW-1:0] c0, c1, c2, c3, target;
    logic          busy, done, found;
    logic [XW-1:0] x_out;
`ifdef POLY_INV_COUNT_EN
    logic [XW:0]   count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    poly_inverse_search #(.XW(XW), .YW(YW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .c0     (c0),
        .c1     (c1),
        .c2     (c2),
        .c3     (c3),
        .target (target),
        .busy   (busy),
        .done   (done),
        .found  (found),
`ifdef POLY_INV_COUNT_EN
        .count  (count),
`endif
        .x_out  (x_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives start before edge E0, optionally re-pulses start (target=0) before edge
    // glitch_edge, and returns the index of the edge after which done was first seen.
    task automatic launch(input logic [YW-1:0] a0, input logic [YW-1:0] a1,
                          input logic [YW-1:0] a2, input logic [YW-1:0] a3,
                          input logic [YW-1:0] tg, input int glitch_edge,
                          output int edges);
        c0 = a0; c1 = a1; c2 = a2; c3 = a3; target = tg;
        start = 1'b1;
        @(posedge clk); #1;          // E0
        start = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            if (glitch_edge != 0 && edges == glitch_edge - 1) begin
                start = 1'b1; target = 5'd0;
            end
            @(posedge clk); #1;
            edges++;
            if (glitch_edge != 0 && edges == glitch_edge) start = 1'b0;
        end
        check_eq("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic finish_pulse(input string tag);
        @(posedge clk); #1;
        check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    int e;

    initial begin
        rst_n = 1'b0; start = 1'b0;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0; target = '0;
        #12;
        check_eq("rst_busy",  32'(busy),  32'd0);
        check_eq("rst_done",  32'(done),  32'd0);
        check_eq("rst_found", 32'(found), 32'd0);
        check_eq("rst_x_out", 32'(x_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: p(0..3)=1,0,7,6, target 7 -> x=2
        c0 = 5'd1; c1 = 5'd27; c2 = 5'd28; c3 = 5'd8; target = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;          // E0
        start = 1'b0;
        check_eq("t1_busy_e0", 32'(busy), 32'd1);
        e = 0;
        while (!done && e < 100) begin
            @(posedge clk); #1;
            e++;
            if (e == 11) check_eq("t1_busy_e11", 32'(busy), 32'd1);
        end
        check_eq("t1_done_seen", 32'(done), 32'd1);
`ifdef POLY_INV_COUNT_EN
        check_eq("t1_latency", 32'(e), 32'd16);
        check_eq("t1_count",   32'(count), 32'd1);
`else
        check_eq("t1_latency", 32'(e), 32'd12);
`endif
        check_eq("t1_busy_in_done", 32'(busy),  32'd0);
        check_eq("t1_found",        32'(found), 32'd1);
        check_eq("t1_x_out",        32'(x_out), 32'd2);
        // start during DONE must not launch a new run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("t1_done_one_cycle", 32'(done), 32'd0);
        @(posedge clk); #1;
        check_eq("t1_start_in_done_ignored", 32'(busy), 32'd0);

        // T2: target 0 -> x=1
        launch(5'd1, 5'd27, 5'd28, 5'd8, 5'd0, 0, e);
`ifdef POLY_INV_COUNT_EN
        check_eq("t2_latency", 32'(e), 32'd16);
        check_eq("t2_count",   32'(count), 32'd1);
`else
        check_eq("t2_latency", 32'(e), 32'd8);
`endif
        check_eq("t2_found", 32'(found), 32'd1);
        check_eq("t2_x_out", 32'(x_out), 32'd1);
        finish_pulse("t2");

        // T3: target 5 -> no solution
        launch(5'd1, 5'd27, 5'd28, 5'd8, 5'd5, 0, e);
        check_eq("t3_latency", 32'(e), 32'd16);
`ifdef POLY_INV_COUNT_EN
        check_eq("t3_count", 32'(count), 32'd0);
`endif
        check_eq("t3_found", 32'(found), 32'd0);
        check_eq("t3_x_out", 32'(x_out), 32'd0);
        finish_pulse("t3");

        // T4: constant 3 -> every x matches, smallest is 0
        launch(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 0, e);
`ifdef POLY_INV_COUNT_EN
        check_eq("t4_latency", 32'(e), 32'd16);
        check_eq("t4_count",   32'(count), 32'd4);
`else
        check_eq("t4_latency", 32'(e), 32'd4);
`endif
        check_eq("t4_found", 32'(found), 32'd1);
        check_eq("t4_x_out", 32'(x_out), 32'd0);
        finish_pulse("t4");

        // T5: T1 with a second start (target 0) at E5 that must be ignored
        launch(5'd1, 5'd27, 5'd28, 5'd8, 5'd7, 5, e);
`ifdef POLY_INV_COUNT_EN
        check_eq("t5_latency", 32'(e), 32'd16);
`else
        check_eq("t5_latency", 32'(e), 32'd12);
`endif
        check_eq("t5_found", 32'(found), 32'd1);
        check_eq("t5_x_out", 32'(x_out), 32'd2);
        finish_pulse("t5");

        // T6: async reset mid-T1 clears outputs immediately, no done pulse
        c0 = 5'd1; c1 = 5'd27; c2 = 5'd28; c3 = 5'd8; target = 5'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy",  32'(busy),  32'd0);
        check_eq("t6_rst_found", 32'(found), 32'd0);
        check_eq("t6_rst_x_out", 32'(x_out), 32'd0);
        e = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) e++;
        end
        check_eq("t6_no_done_in_reset", 32'(e), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        launch(5'd1, 5'd27, 5'd28, 5'd8, 5'd0, 0, e);
`ifdef POLY_INV_COUNT_EN
        check_eq("t6_t2_latency", 32'(e), 32'd16);
`else
        check_eq("t6_t2_latency", 32'(e), 32'd8);
`endif
        check_eq("t6_t2_found", 32'(found), 32'd1);
        check_eq("t6_t2_x_out", 32'(x_out), 32'd1);
        finish_pulse("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
